// File: rtl/qft_state_serializer.sv
// Output stage of the 3-qubit QFT: captures one 8-amplitude state vector per frame and
// streams it out one basis state per beat, |000> first, with the saturated probability |a|^2.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 8
`endif

module qft_state_serializer #(
   parameter int W = `TOTAL_WIDTH,
   parameter int F = `FRAC_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*W-1:0]      in_r,
   input  logic [8*W-1:0]      in_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2:0]          out_idx,
   output logic signed [W-1:0] out_r,
   output logic signed [W-1:0] out_i,
   output logic [W-1:0]        out_prob,
   output logic                out_last,
   output logic                drop_err
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [W-1:0] PROB_MAX = {1'b0, {(W-1){1'b1}}};

   state_t state, state_nxt;

   logic signed [W-1:0] buf_r [8];
   logic signed [W-1:0] buf_i [8];

   logic                xfer;
   logic                last_xfer;
   logic                accept;
   logic                advance;
   logic [2:0]          idx_nxt;
   logic signed [W-1:0] sel_r;
   logic signed [W-1:0] sel_i;

   // r*r + i*i is non-negative, so the sum is handled as unsigned in 2W+1 bits.
   function automatic logic [W-1:0] prob_of(input logic signed [W-1:0] r,
                                            input logic signed [W-1:0] i);
      logic signed [2*W-1:0] rr;
      logic signed [2*W-1:0] ii;
      logic [2*W:0]          sum;
      logic [2*W:0]          shifted;
      rr      = (2*W)'(r) * (2*W)'(r);
      ii      = (2*W)'(i) * (2*W)'(i);
      sum     = {1'b0, rr} + {1'b0, ii};
      shifted = sum >> F;
      if (shifted > {{(W+1){1'b0}}, PROB_MAX}) begin
         return PROB_MAX;
      end
      return shifted[W-1:0];
   endfunction

   assign out_valid = (state == STREAM);
   assign out_last  = out_valid & (out_idx == 3'd7);

   always_comb begin
      state_nxt = state;
      xfer      = out_valid & out_ready;
      last_xfer = xfer & (out_idx == 3'd7);
      in_ready  = (state == IDLE) | last_xfer;
      accept    = in_valid & in_ready;
      advance   = xfer & ~last_xfer;
      idx_nxt   = out_idx + 3'd1;
      // A new frame presents beat 0 straight from the input bus, since the buffer loads on the same edge.
      sel_r     = accept ? in_r[W-1:0] : buf_r[idx_nxt];
      sel_i     = accept ? in_i[W-1:0] : buf_i[idx_nxt];
      if (state == IDLE) begin
         if (accept) begin
            state_nxt = STREAM;
         end
      end else begin
         if (last_xfer && !accept) begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) begin
            buf_r[k] <= '0;
            buf_i[k] <= '0;
         end
         out_idx  <= 3'd0;
         out_r    <= '0;
         out_i    <= '0;
         out_prob <= '0;
         drop_err <= 1'b0;
      end else begin
         if (accept) begin
            for (int k = 0; k < 8; k++) begin
               buf_r[k] <= in_r[k*W +: W];
               buf_i[k] <= in_i[k*W +: W];
            end
            out_idx <= 3'd0;
         end else if (advance) begin
            out_idx <= idx_nxt;
         end
         if (accept | advance) begin
            out_r    <= sel_r;
            out_i    <= sel_i;
            out_prob <= prob_of(sel_r, sel_i);
         end
         if (in_valid & ~in_ready) begin
            drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_qft_state_serializer.sv
// Bench for qft_state_serializer: directed frames plus random amplitudes and random
// consumer backpressure, checked beat by beat against a plain arithmetic model.

module tb_qft_state_serializer;

   localparam int W = 16;
   localparam int F = 8;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [8*W-1:0]      in_r;
   logic [8*W-1:0]      in_i;
   logic                out_valid;
   logic                out_ready;
   logic [2:0]          out_idx;
   logic signed [W-1:0] out_r;
   logic signed [W-1:0] out_i;
   logic [W-1:0]        out_prob;
   logic                out_last;
   logic                drop_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_r [8];
   int cur_i [8];
   int nxt_r [8];
   int nxt_i [8];
   int cyc;

   qft_state_serializer #(.W(W), .F(F)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_r     (out_r),
      .out_i     (out_i),
      .out_prob  (out_prob),
      .out_last  (out_last),
      .drop_err  (drop_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int model_prob(int r, int i);
      longint p;
      longint pmax;
      pmax = (longint'(1) << (W-1)) - 1;
      p = (longint'(r) * longint'(r) + longint'(i) * longint'(i)) / (longint'(1) << F);
      if (p > pmax) p = pmax;
      return int'(p);
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_bus(input bit use_nxt);
      for (int k = 0; k < 8; k++) begin
         in_r[k*W +: W] = use_nxt ? nxt_r[k][W-1:0] : cur_r[k][W-1:0];
         in_i[k*W +: W] = use_nxt ? nxt_i[k][W-1:0] : cur_i[k][W-1:0];
      end
   endtask

   task automatic random_cur();
      for (int k = 0; k < 8; k++) begin
         cur_r[k] = int'($urandom_range(0, 65535)) - 32768;
         cur_i[k] = int'($urandom_range(0, 65535)) - 32768;
      end
   endtask

   task automatic offer();
      set_bus(1'b0);
      in_valid = 1'b1;
      #1;
      check("offer_in_ready", in_ready, 1);
      check("offer_not_early", out_valid, 0);
      step();
      in_valid = 1'b0;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic drain(input int mode, input bit b2b, input int drop_at,
                        input int rst_at, output int cycles);
      int                  e;
      bit                  stalled;
      bit                  dropped;
      bit                  done;
      logic signed [W-1:0] s_r;
      logic signed [W-1:0] s_i;
      logic [W-1:0]        s_p;
      logic [2:0]          s_idx;
      e = 0; stalled = 0; dropped = 0; done = 0; cycles = 0;
      s_r = '0; s_i = '0; s_p = '0; s_idx = '0;
      for (int c = 0; c < 300 && !done; c++) begin
         in_valid = 1'b0;
         if (mode == 0)      out_ready = 1'b1;
         else if (mode == 1) out_ready = (c % 4 == 0) || (c % 4 == 3);
         else                out_ready = 1'($urandom_range(0, 1));
         #1;
         check("beat_valid", out_valid, 1);
         if (stalled) begin
            check("stall_idx", out_idx, s_idx);
            check("stall_r", out_r, s_r);
            check("stall_i", out_i, s_i);
            check("stall_prob", out_prob, s_p);
         end
         if (dropped) check("drop_sticky", drop_err, 1);
         if (out_valid) begin
            check("beat_idx", out_idx, e);
            check("beat_r", out_r, cur_r[e]);
            check("beat_i", out_i, cur_i[e]);
            check("beat_prob", out_prob, model_prob(cur_r[e], cur_i[e]));
            check("beat_last", out_last, e == 7);
            if (e == rst_at) begin
               rst = 1'b1;
               #1;
               check("rst_valid", out_valid, 0);
               check("rst_idx", out_idx, 0);
               check("rst_r", out_r, 0);
               check("rst_prob", out_prob, 0);
               check("rst_drop_err", drop_err, 0);
               check("rst_in_ready", in_ready, 1);
               done = 1;
            end else begin
               if (e == drop_at && !dropped) begin
                  for (int k = 0; k < 8; k++) begin
                     in_r[k*W +: W] = W'($urandom);
                     in_i[k*W +: W] = W'($urandom);
                  end
                  in_valid = 1'b1;
                  #1;
                  check("drop_in_ready", in_ready, 0);
                  dropped = 1;
               end
               if (b2b && e == 7 && out_ready) begin
                  set_bus(1'b1);
                  in_valid = 1'b1;
                  #1;
                  check("b2b_in_ready", in_ready, 1);
               end
               stalled = !out_ready;
               s_r = out_r; s_i = out_i; s_p = out_prob; s_idx = out_idx;
               if (out_ready) e++;
               if (e == 8) done = 1;
            end
         end
         cycles++;
         step();
      end
      if (rst_at < 0) check("stream_done", e, 8);
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic post_idle();
      #1;
      check("idle_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_last", out_last, 0);
      check("hold_idx", out_idx, 7);
      check("hold_r", out_r, cur_r[7]);
      check("hold_prob", out_prob, model_prob(cur_r[7], cur_i[7]));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_r = '0; in_i = '0;
      @(negedge clk);
      check("reset_valid", out_valid, 0);
      check("reset_idx", out_idx, 0);
      check("reset_r", out_r, 0);
      check("reset_i", out_i, 0);
      check("reset_prob", out_prob, 0);
      check("reset_last", out_last, 0);
      check("reset_drop_err", drop_err, 0);
      check("reset_in_ready", in_ready, 1);
      rst = 1'b0;

      // single frame, consumer always ready
      for (int k = 0; k < 8; k++) begin
         cur_r[k] = k * (1 << F) / 8;
         cur_i[k] = -cur_r[k];
      end
      offer();
      drain(0, 1'b0, -1, -1, cyc);
      check("single_cycles", cyc, 8);
      post_idle();

      // same frame under 1,0,0,1 backpressure
      offer();
      drain(1, 1'b0, -1, -1, cyc);
      post_idle();

      // back-to-back via the idx-7 overlap
      for (int k = 0; k < 8; k++) begin
         nxt_r[k] = 1 << (F - 1);
         nxt_i[k] = 0;
      end
      offer();
      drain(0, 1'b1, -1, -1, cyc);
      cur_r = nxt_r;
      cur_i = nxt_i;
      drain(0, 1'b0, -1, -1, cyc);
      check("b2b_cycles", cyc, 8);
      post_idle();

      // drop while streaming idx 3
      random_cur();
      offer();
      drain(2, 1'b0, 3, -1, cyc);
      post_idle();
      check("drop_kept", drop_err, 1);

      // saturation
      for (int k = 0; k < 8; k++) begin
         cur_r[k] = -32768;
         cur_i[k] = (k < 4) ? -32768 : 32767;
      end
      offer();
      drain(0, 1'b0, -1, -1, cyc);
      post_idle();

      // reset mid-stream at idx 5, then a fresh frame
      random_cur();
      offer();
      drain(0, 1'b0, -1, 5, cyc);
      #1;
      check("after_rst_valid", out_valid, 0);
      check("after_rst_drop_err", drop_err, 0);
      random_cur();
      offer();
      drain(0, 1'b0, -1, -1, cyc);
      post_idle();

      // random frames with random backpressure
      for (int n = 0; n < 6; n++) begin
         random_cur();
         offer();
         drain(2, 1'b0, -1, -1, cyc);
         post_idle();
      end
      check("final_drop_err", drop_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
